// File: rtl/elbeth_fetch_ctrl.sv
// rtl/elbeth_fetch_ctrl.sv - ELBETH instruction-fetch sequencer: PC, imem handshake, skid buffer, redirect drain
// Optional macro ELBETH_MISALIGN_TRAP_EN: misaligned branch targets redirect to TRAP_PC and pulse misalign_exc.
module elbeth_fetch_ctrl #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic        branch_taken,
   input  logic [31:0] pc_branch,
   input  logic        stall,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_data,
   output logic        if_valid,
   output logic [31:0] if_pc,
   output logic [31:0] if_instr,
   output logic        flush,
   output logic        misalign_exc
);
   localparam logic [1:0]  ST_BOOT  = 2'd0;
   localparam logic [1:0]  ST_FETCH = 2'd1;
   localparam logic [1:0]  ST_DRAIN = 2'd2;
   localparam logic [31:0] NOP      = 32'h0000_0013;

   logic [1:0]  state;
   logic [31:0] pc;
   logic [31:0] pending_pc;
   logic [31:0] pc_next;
   logic [31:0] target;
   logic [31:0] skid_pc;
   logic [31:0] skid_instr;
   logic        skid_valid;
   logic        redir;
   logic        fire;

   assign redir     = id_valid & branch_taken & ~stall & (state != ST_BOOT);
   assign flush     = redir;
   assign pc_next   = pc + 32'd4;
   // pc only moves on a completed fetch, so the address is stable while a request is pending
   assign imem_addr = pc;

   always_comb begin
      imem_req = 1'b0;
      case (state)
         ST_FETCH: imem_req = ~skid_valid;
         ST_DRAIN: imem_req = 1'b1;
         default:  imem_req = 1'b0;
      endcase
   end

   assign fire = imem_req & imem_ready;

`ifdef ELBETH_MISALIGN_TRAP_EN
   logic misaligned;
   assign misaligned = |pc_branch[1:0];
   assign target     = misaligned ? TRAP_PC : {pc_branch[31:2], 2'b00};

   always_ff @(posedge clk) begin
      if (rst) begin
         misalign_exc <= 1'b0;
      end else begin
         misalign_exc <= redir & misaligned;
      end
   end
`else
   logic unused_low_bits;
   assign unused_low_bits = ^pc_branch[1:0];
   assign target          = {pc_branch[31:2], 2'b00};
   assign misalign_exc    = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= ST_BOOT;
         pc         <= RESET_PC;
         pending_pc <= RESET_PC;
         skid_valid <= 1'b0;
         skid_pc    <= 32'h0;
         skid_instr <= NOP;
         if_valid   <= 1'b0;
         if_pc      <= 32'h0;
         if_instr   <= NOP;
      end else begin
         case (state)
            ST_BOOT: state <= ST_FETCH;
            ST_FETCH: begin
               if (redir) begin
                  if_valid   <= 1'b0;
                  skid_valid <= 1'b0;
                  // With nothing outstanding there is no wrong-path response to wait for
                  if (imem_ready || !imem_req) begin
                     pc <= target;
                  end else begin
                     pending_pc <= target;
                     state      <= ST_DRAIN;
                  end
               end else if (stall) begin
                  if (fire) begin
                     skid_pc    <= pc;
                     skid_instr <= imem_data;
                     skid_valid <= 1'b1;
                     pc         <= pc_next;
                  end
               end else if (skid_valid) begin
                  if_pc      <= skid_pc;
                  if_instr   <= skid_instr;
                  if_valid   <= 1'b1;
                  skid_valid <= 1'b0;
               end else if (fire) begin
                  if_pc    <= pc;
                  if_instr <= imem_data;
                  if_valid <= 1'b1;
                  pc       <= pc_next;
               end else begin
                  if_valid <= 1'b0;
               end
            end
            ST_DRAIN: begin
               if_valid <= 1'b0;
               if (fire) begin
                  pc    <= redir ? target : pending_pc;
                  state <= ST_FETCH;
               end else if (redir) begin
                  pending_pc <= target;
               end
            end
            default: state <= ST_BOOT;
         endcase
      end
   end
endmodule
